// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and load/store clients onto a byte-wide RAM/IO bus,
// splitting accesses into byte cycles and reassembling/extending load data.
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_data,
  input  logic        request,
  input  logic        load_or_store,
  input  logic [5:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        mem_valid,
  output logic [31:0] mem_val
);

  localparam logic [5:0] Lb  = 6'd1;
  localparam logic [5:0] Lh  = 6'd2;
  localparam logic [5:0] Lw  = 6'd3;
  localparam logic [5:0] Lbu = 6'd4;
  localparam logic [5:0] Lhu = 6'd5;
  localparam logic [5:0] Sb  = 6'd6;
  localparam logic [5:0] Sh  = 6'd7;
  localparam logic [5:0] Sw  = 6'd8;

  localparam logic [31:0] IO0 = 32'h0003_0000;
  localparam logic [31:0] IO1 = 32'h0003_0004;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_q;
  logic        is_if_q;
  logic        clr_q;
  logic [5:0]  op_q;
  logic [31:0] base_q;
  logic [31:0] data_q;
  logic [31:0] buf_q;
  logic [2:0]  len_q;
  logic [2:0]  cnt_q;

  logic [31:0] addr_d;
  logic        stall_d;
  logic [7:0]  wbyte_d;
  logic [1:0]  cap_idx;
  logic [31:0] word_d;
  logic [31:0] ext_d;
  logic [31:0] in_addr;
  logic        in_st;
  logic        in_stall;
  logic [2:0]  in_len;

  function automatic logic [2:0] len_of(input logic [5:0] op);
    case (op)
      Lb, Lbu, Sb: len_of = 3'd1;
      Lh, Lhu, Sh: len_of = 3'd2;
      default:     len_of = 3'd4;
    endcase
  endfunction

  always_comb begin
    addr_d  = base_q + {29'd0, cnt_q};
    stall_d = io_buffer_full && (addr_d == IO0 || addr_d == IO1);
    wbyte_d = data_q[{cnt_q[1:0], 3'b000} +: 8];
    // byte captured at edge k+2 belongs to address A+k
    cap_idx = cnt_q[1:0] - 2'd2;
    word_d  = buf_q;
    word_d[{cap_idx, 3'b000} +: 8] = mem_din;
    case (op_q)
      Lb:      ext_d = {{24{word_d[7]}}, word_d[7:0]};
      Lh:      ext_d = {{16{word_d[15]}}, word_d[15:0]};
      Lbu:     ext_d = {24'd0, word_d[7:0]};
      Lhu:     ext_d = {16'd0, word_d[15:0]};
      default: ext_d = word_d;
    endcase
    in_addr  = request ? mem_addr : if_addr;
    in_st    = request && load_or_store;
    in_stall = in_st && io_buffer_full &&
               (in_addr == IO0 || in_addr == IO1);
    in_len   = request ? len_of(mem_op) : 3'd4;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      is_if_q   <= 1'b0;
      clr_q     <= 1'b0;
      op_q      <= 6'd0;
      base_q    <= 32'd0;
      data_q    <= 32'd0;
      buf_q     <= 32'd0;
      len_q     <= 3'd0;
      cnt_q     <= 3'd0;
      mem_a     <= 32'd0;
      mem_dout  <= 8'd0;
      mem_wr    <= 1'b0;
      if_valid  <= 1'b0;
      if_data   <= 32'd0;
      mem_valid <= 1'b0;
      mem_val   <= 32'd0;
    end else if (rdy_in) begin
      if_valid  <= 1'b0;
      mem_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          mem_wr <= 1'b0;
          if (!clear && (request || if_req)) begin
            is_if_q <= !request;
            clr_q   <= 1'b0;
            op_q    <= request ? mem_op : Lw;
            base_q  <= in_addr;
            data_q  <= mem_data;
            buf_q   <= 32'd0;
            len_q   <= in_len;
            mem_a   <= in_addr;
            if (in_st) begin
              state_q  <= WRITE;
              mem_dout <= mem_data[7:0];
              mem_wr   <= !in_stall;
              cnt_q    <= in_stall ? 3'd0 : 3'd1;
            end else begin
              state_q <= READ;
              cnt_q   <= 3'd1;
            end
          end
        end
        READ: begin
          if (clear) begin
            state_q <= DONE;
            cnt_q   <= 3'd0;
          end else begin
            if (cnt_q < len_q) mem_a <= addr_d;
            if (cnt_q >= 3'd2) buf_q <= word_d;
            if (cnt_q == len_q + 3'd1) begin
              if (is_if_q) begin
                if_valid <= 1'b1;
                if_data  <= word_d;
              end else begin
                mem_valid <= 1'b1;
                mem_val   <= ext_d;
              end
              state_q <= DONE;
              cnt_q   <= 3'd0;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        WRITE: begin
          if (cnt_q == len_q) begin
            mem_wr    <= 1'b0;
            mem_valid <= !(clr_q || clear);
            state_q   <= DONE;
            cnt_q     <= 3'd0;
          end else begin
            // a flushed store still drains its bytes, only the pulse is lost
            clr_q    <= clr_q || clear;
            mem_a    <= addr_d;
            mem_dout <= wbyte_d;
            mem_wr   <= !stall_d;
            if (!stall_d) cnt_q <= cnt_q + 3'd1;
          end
        end
        DONE: begin
          mem_wr  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vectors for mem_ctrl against a byte RAM model
// with one cycle of read latency.
module tb_mem_ctrl;

  localparam logic [5:0] Lb  = 6'd1;
  localparam logic [5:0] Lh  = 6'd2;
  localparam logic [5:0] Lw  = 6'd3;
  localparam logic [5:0] Lbu = 6'd4;
  localparam logic [5:0] Lhu = 6'd5;
  localparam logic [5:0] Sb  = 6'd6;
  localparam logic [5:0] Sh  = 6'd7;
  localparam logic [5:0] Sw  = 6'd8;

  logic        clk_in = 0;
  logic        rst_in = 1;
  logic        rdy_in = 1;
  logic        clear = 0;
  logic        io_buffer_full = 0;
  logic [7:0]  mem_din = 0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req = 0;
  logic [31:0] if_addr = 0;
  logic        if_valid;
  logic [31:0] if_data;
  logic        request = 0;
  logic        load_or_store = 0;
  logic [5:0]  mem_op = 0;
  logic [31:0] mem_addr = 0;
  logic [31:0] mem_data = 0;
  logic        mem_valid;
  logic [31:0] mem_val;

  int n_chk = 0;
  int n_fail = 0;
  int ifv_n = 0;
  int mv_n = 0;
  int wr_n = 0;

  logic [7:0]  ram [0:65535];
  logic [31:0] wa_q [$];
  logic [7:0]  wd_q [$];

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .clear(clear), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .if_req(if_req), .if_addr(if_addr),
    .if_valid(if_valid), .if_data(if_data), .request(request),
    .load_or_store(load_or_store), .mem_op(mem_op),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_valid(mem_valid), .mem_val(mem_val)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    mem_din <= ram[mem_a[15:0]];
    if (mem_wr) begin
      ram[mem_a[15:0]] <= mem_dout;
      wa_q.push_back(mem_a);
      wd_q.push_back(mem_dout);
      wr_n++;
    end
  end

  always @(negedge clk_in) begin
    if (if_valid) ifv_n++;
    if (mem_valid) mv_n++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input bit want_if, output int lat);
    lat = -1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk_in);
      #1;
      if (want_if ? if_valid : mem_valid) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic lsb_op(input logic ls, input logic [5:0] op,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] val);
    @(negedge clk_in);
    request = 1; load_or_store = ls; mem_op = op;
    mem_addr = a; mem_data = d;
    wait_valid(0, lat);
    val = mem_val;
    @(negedge clk_in);
    request = 0;
    @(posedge clk_in);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, output int lat,
                       output logic [31:0] val);
    @(negedge clk_in);
    if_req = 1; if_addr = a;
    wait_valid(1, lat);
    val = if_data;
    @(negedge clk_in);
    if_req = 0;
    @(posedge clk_in);
    #1;
  endtask

  int          lat;
  logic [31:0] val;
  int          c0;

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1000] = 8'h13;
    ram[16'h0020] = 8'h80;
    ram[16'h0040] = 8'h34;
    ram[16'h0041] = 8'hF2;
    ram[16'h0042] = 8'h56;
    ram[16'h0043] = 8'h78;

    #2;
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
    check("rst_valids", {30'd0, if_valid, mem_valid}, 32'h0);
    check("rst_data", if_data | mem_val | {24'd0, mem_dout}, 32'h0);
    @(negedge clk_in);
    rst_in = 0;

    // fetch with per-cycle address check
    @(negedge clk_in);
    wr_n = 0;
    if_req = 1; if_addr = 32'h1000;
    for (int e = 0; e <= 5; e++) begin
      @(posedge clk_in);
      #1;
      if (e < 4) check($sformatf("fetch_a%0d", e), mem_a, 32'h1000 + e);
      check($sformatf("fetch_v%0d", e), {31'd0, if_valid},
            (e == 5) ? 32'd1 : 32'd0);
    end
    check("fetch_data", if_data, 32'h0000_0013);
    @(negedge clk_in);
    if_req = 0;
    @(posedge clk_in);
    #1;
    check("fetch_no_wr", wr_n, 0);

    lsb_op(0, Lb, 32'h20, 0, lat, val);
    check("lb_lat", lat, 2);
    check("lb_val", val, 32'hFFFF_FF80);

    // global stall before accept, mem_a stays at the last Lb address
    @(negedge clk_in);
    rdy_in = 0;
    c0 = mv_n;
    request = 1; load_or_store = 0; mem_op = Lw; mem_addr = 32'h40;
    repeat (3) @(posedge clk_in);
    #1;
    check("rdy_hold_a", mem_a, 32'h20);
    check("rdy_no_valid", mv_n, c0);
    @(negedge clk_in);
    rdy_in = 1;
    wait_valid(0, lat);
    check("rdy_lw_lat", lat, 5);
    check("rdy_lw_val", mem_val, 32'h7856_F234);
    @(negedge clk_in);
    request = 0;
    @(posedge clk_in);
    #1;

    lsb_op(0, Lbu, 32'h20, 0, lat, val);
    check("lbu_val", val, 32'h0000_0080);
    lsb_op(0, Lh, 32'h40, 0, lat, val);
    check("lh_lat", lat, 3);
    check("lh_val", val, 32'hFFFF_F234);
    lsb_op(0, Lhu, 32'h40, 0, lat, val);
    check("lhu_val", val, 32'h0000_F234);

    // store and fetch together: store wins
    @(negedge clk_in);
    wa_q.delete(); wd_q.delete();
    request = 1; load_or_store = 1; mem_op = Sw;
    mem_addr = 32'h100; mem_data = 32'hDEAD_BEEF;
    if_req = 1; if_addr = 32'h1000;
    for (int e = 0; e <= 6; e++) begin
      @(posedge clk_in);
      #1;
      if (e <= 4) check($sformatf("sw_v%0d", e), {31'd0, mem_valid},
                        (e == 4) ? 32'd1 : 32'd0);
      if (e == 4) request = 0;
      if (e == 5) check("sw_done_a", mem_a, 32'h103);
      if (e == 6) check("sw_then_fetch_a", mem_a, 32'h1000);
    end
    wait_valid(1, lat);
    check("sw_fetch_lat", lat, 4);
    check("sw_fetch_data", if_data, 32'h13);
    @(negedge clk_in);
    if_req = 0;
    @(posedge clk_in);
    #1;
    check("sw_nwr", wa_q.size(), 4);
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      check($sformatf("sw_a%0d", i), wa_q[i], 32'h100 + i);
      check($sformatf("sw_d%0d", i), {24'd0, wd_q[i]},
            (32'hDEAD_BEEF >> (8 * i)) & 32'hFF);
    end

    // IO stall on UART address
    @(negedge clk_in);
    wa_q.delete(); wd_q.delete();
    io_buffer_full = 1;
    request = 1; load_or_store = 1; mem_op = Sb;
    mem_addr = 32'h3_0000; mem_data = 32'h41;
    for (int e = 0; e <= 4; e++) begin
      @(posedge clk_in);
      #1;
      if (e < 3) check($sformatf("io_stall%0d", e), {31'd0, mem_wr}, 0);
      if (e == 2) io_buffer_full = 0;
      if (e == 3) begin
        check("io_wr", {31'd0, mem_wr}, 1);
        check("io_a", mem_a, 32'h3_0000);
        check("io_v3", {31'd0, mem_valid}, 0);
      end
      if (e == 4) check("io_v4", {31'd0, mem_valid}, 1);
    end
    request = 0;
    @(posedge clk_in);
    #1;
    check("io_nwr", wa_q.size(), 1);
    if (wa_q.size() > 0) check("io_d", {24'd0, wd_q[0]}, 32'h41);

    // flush during fetch
    @(negedge clk_in);
    c0 = ifv_n;
    if_req = 1; if_addr = 32'h1000;
    repeat (2) @(posedge clk_in);
    #1;
    clear = 1;
    @(posedge clk_in);
    #1;
    clear = 0; if_req = 0;
    repeat (6) @(posedge clk_in);
    #1;
    check("clr_fetch_nov", ifv_n, c0);

    // flush during halfword store
    @(negedge clk_in);
    wa_q.delete(); wd_q.delete();
    c0 = mv_n;
    request = 1; load_or_store = 1; mem_op = Sh;
    mem_addr = 32'h80; mem_data = 32'h5A6B;
    @(posedge clk_in);
    #1;
    clear = 1;
    @(posedge clk_in);
    #1;
    clear = 0; request = 0;
    repeat (3) @(posedge clk_in);
    #1;
    check("clr_sh_nwr", wa_q.size(), 2);
    if (wa_q.size() == 2) begin
      check("clr_sh_a1", wa_q[1], 32'h81);
      check("clr_sh_d0", {24'd0, wd_q[0]}, 32'h6B);
      check("clr_sh_d1", {24'd0, wd_q[1]}, 32'h5A);
    end
    check("clr_sh_nov", mv_n, c0);
    lsb_op(0, Lb, 32'h20, 0, lat, val);
    check("after_clr_lat", lat, 2);
    check("after_clr_val", val, 32'hFFFF_FF80);

    // async reset mid word load
    @(negedge clk_in);
    request = 1; load_or_store = 0; mem_op = Lw; mem_addr = 32'h40;
    repeat (3) @(posedge clk_in);
    #1;
    check("pre_rst_a", mem_a, 32'h42);
    #2;
    rst_in = 1;
    #1;
    check("arst_mem_a", mem_a, 32'h0);
    check("arst_dout", {24'd0, mem_dout}, 32'h0);
    check("arst_if_data", if_data, 32'h0);
    check("arst_mem_val", mem_val, 32'h0);
    check("arst_flags", {29'd0, mem_wr, if_valid, mem_valid}, 32'h0);
    request = 0;
    @(negedge clk_in);
    rst_in = 0;
    fetch(32'h1000, lat, val);
    check("post_rst_lat", lat, 5);
    check("post_rst_data", val, 32'h13);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the core's two memory clients (instruction fetch and the load/store buffer) and the byte-wide external RAM/IO bus. It arbitrates the clients, splits each 1/2/4-byte access into sequential byte cycles, and reassembles and extends load data. It also stalls UART writes while the IO buffer is full and aborts speculative traffic on pipeline clear.

## Interface
- No parameters. Op codes (`Lb`, `Lh`, `Lw`, `Lbu`, `Lhu`, `Sb`, `Sh`, `Sw`) come from const.v.
- clk_in  input  1  sole clock, rising edge
- rst_in  input  1  asynchronous, active-high reset
- rdy_in  input  1  global enable; when low, all state and outputs hold
- clear  input  1  pipeline flush (mispredict)
- io_buffer_full  input  1  UART TX buffer full
- mem_din  input  8  RAM read byte, valid one cycle after its address
- mem_dout  output  8  RAM write byte
- mem_a  output  32  RAM byte address
- mem_wr  output  1  1 = write this cycle
- if_req  input  1  fetch request, held until if_valid
- if_addr  input  32  fetch address (4 bytes)
- if_valid  output  1  one-cycle fetch done pulse
- if_data  output  32  fetched word, little-endian
- request  input  1  LSB request, held until mem_valid
- load_or_store  input  1  0 = load, 1 = store
- mem_op  input  6  access op code
- mem_addr  input  32  access address
- mem_data  input  32  store data (low n bytes used)
- mem_valid  output  1  one-cycle LSB done pulse
- mem_val  output  32  extended load data (undefined for stores)

## Operation
- States: IDLE, READ, WRITE, DONE. Byte counter k (0..3). Length n = 1 for Lb/Lbu/Sb, 2 for Lh/Lhu/Sh, 4 for Lw/Sw/fetch.
- IDLE arbitration (fixed priority): request > if_req. Latch the client, base address A, n, op and data.
- READ: drive mem_a = A+k at each successive edge, k = 0..n-1, with mem_wr = 0. Sample mem_din two edges after its address and shift it into byte position k.
- WRITE: each cycle k drives mem_wr = 1, mem_a = A+k and mem_dout = data[8k+7:8k]. Addresses wrap modulo 2^32.
- IO stall: a WRITE cycle with A+k in {0x30000, 0x30004} while io_buffer_full = 1 drives mem_wr = 0 and holds k. The stall ends when io_buffer_full falls.
- Load extension:
  - Lb: sign-extend bit 7.
  - Lh: sign-extend bit 15.
  - Lbu/Lhu: zero-extend.
  - Lw/fetch: no extension.
- Completion: pulse mem_valid or if_valid for one cycle with data valid in the same cycle, then enter DONE.
- DONE lasts one cycle, ignores all requests, then returns to IDLE. This prevents re-accepting the request the client is still dropping.
- clear, sampled at any edge:
  - Fetch or load in progress: abort and go to DONE with no valid pulse.
  - Store in progress: finish all remaining bytes, suppress mem_valid.
  - IDLE: nothing is accepted that edge.
- Simultaneous clear and completion edge: the valid pulse is suppressed.

## Timing
- Reset values: mem_a = 0, mem_dout = 0, mem_wr = 0, if_valid = 0, if_data = 0, mem_valid = 0, mem_val = 0, state = IDLE, k = 0.
- Edge E0 is the IDLE edge that accepts a request. mem_a/mem_wr/mem_dout are registered and change starting at E0.
- Read of n bytes:
  - Addresses A..A+n-1 are presented from edges E0..E(n-1).
  - Byte k is captured at E(k+2).
  - The valid pulse is registered at E(n+1), giving a latency of n+1 cycles (Lw/fetch: 5, Lb: 2).
- Write of n bytes, no stall:
  - mem_wr = 1 for cycles E0..E(n-1).
  - At E(n), mem_wr goes to 0 and mem_valid goes to 1.
  - Each stall cycle adds one cycle.
- Back-to-back: the earliest next accept is E(valid)+2 (after DONE).
- rdy_in = 0 freezes k, state and all outputs, including mem_wr. The stale access repeats harmlessly; reads resume with correct capture alignment.

## Test plan
- Fetch of 0x1000 with RAM bytes 13 00 00 00: 4 addresses 0x1000–0x1003 on consecutive cycles, if_valid at E5 with if_data = 0x00000013, mem_wr never 1.
- Lb at 0x20 with byte 0x80: mem_val = 0xFFFFFF80 at E2. Lbu at the same address: mem_val = 0x00000080. Lh with bytes 34 F2: mem_val = 0xFFFFF234.
- Sw 0xDEADBEEF to 0x100 issued in the same cycle as if_req: writes EF, BE, AD, DE to 0x100–0x103, mem_valid at E4, then DONE, then fetch accepted (LSB priority).
- Sb 0x41 to 0x30000 with io_buffer_full = 1 for 3 cycles: mem_wr held 0 for 3 cycles, then one write, mem_valid one cycle later.
- clear during fetch cycle 2: no if_valid. clear during Sh: both bytes written, no mem_valid. Next request accepted after DONE.
- rst_in asserted mid-Lw without a clock edge: all outputs return to reset values immediately. After release, a new fetch completes normally.
